line_buffer_flush: RTL and testbench

- Sits directly downstream of bla_wrapper.
- On bla_done, takes a snapshot of the 4096-bit rasterised line_buffer (a 64x64 tile bitmap).
- Scans the snapshot in 32-bit words and writes each non-empty word to frame-buffer memory over a req/ack handshake.
- Frees bla_wrapper to rasterise the next primitive while the previous tile drains.

---
 rtl/line_buffer_flush.sv | 136 +++++++++++++
 tb/tb_line_buffer_flush.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_flush.sv
// line_buffer_flush: snapshots a rasterised line buffer on bla_done and drains
// its non-empty words to frame-buffer memory over a req/ack write handshake,
// so the rasteriser can start on the next primitive while this tile drains.
module line_buffer_flush #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 128,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned SKIP_ZERO = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bla_done,
    input  logic [NUM_WORDS*WORD_W-1:0] line_buffer,
    input  logic [ADDR_W-1:0]           fb_base,
    output logic                        fb_wr_en,
    output logic [ADDR_W-1:0]           fb_addr,
    output logic [WORD_W-1:0]           fb_wdata,
    input  logic                        fb_ack,
    output logic                        flush_busy,
    output logic                        flush_done,
    output logic [7:0]                  words_written
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]       CNT_MAX  = 8'(NUM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_shadow [NUM_WORDS];
    logic [ADDR_W-1:0]   r_base_q;
    logic [IDX_W-1:0]    r_idx;
    logic                r_fb_wr_en;
    logic [ADDR_W-1:0]   r_fb_addr;
    logic [WORD_W-1:0]   r_fb_wdata;
    logic                r_flush_busy;
    logic                r_flush_done;
    logic [7:0]          r_words_written;

    logic [WORD_W-1:0]   w_lb_words [NUM_WORDS];
    logic [WORD_W-1:0]   w_word;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_skip;
    logic                w_last;

    // Split the flat input bitmap into words; word k sits at bits [WORD_W*k +: WORD_W].
    for (genvar g = 0; g < int'(NUM_WORDS); g++) begin : g_split
        assign w_lb_words[g] = line_buffer[g*WORD_W +: WORD_W];
    end

    assign w_word = r_shadow[r_idx];
    assign w_addr = ADDR_W'(r_base_q + ADDR_W'(r_idx));
    assign w_skip = (SKIP_ZERO != 0) && (w_word == '0);
    assign w_last = (r_idx == LAST_IDX);

    // Flush sequencer: capture, scan/skip, hold write until ack, one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_shadow        <= '{default: '0};
            r_base_q        <= '0;
            r_idx           <= '0;
            r_fb_wr_en      <= 1'b0;
            r_fb_addr       <= '0;
            r_fb_wdata      <= '0;
            r_flush_busy    <= 1'b0;
            r_flush_done    <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bla_done) begin
                        r_shadow        <= w_lb_words;
                        r_base_q        <= fb_base;
                        r_idx           <= '0;
                        r_words_written <= '0;
                        r_flush_busy    <= 1'b1;
                        r_state         <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_skip) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_fb_addr  <= w_addr;
                        r_fb_wdata <= w_word;
                        r_fb_wr_en <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Request, address and data stay put until the frame buffer takes them.
                    if (fb_ack) begin
                        r_fb_wr_en <= 1'b0;
                        if (r_words_written != CNT_MAX) begin
                            r_words_written <= r_words_written + 8'd1;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    r_flush_busy <= 1'b0;
                    r_flush_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fb_wr_en      = r_fb_wr_en;
    assign fb_addr       = r_fb_addr;
    assign fb_wdata      = r_fb_wdata;
    assign flush_busy    = r_flush_busy;
    assign flush_done    = r_flush_done;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_line_buffer_flush.sv
// Bench for line_buffer_flush: transaction-level reference (list of expected
// writes plus arithmetic timing) checked every cycle, with directed and random flushes.
module tb_line_buffer_flush;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 128;
    localparam int ADDR_W    = 16;
    localparam int BW        = WORD_W * NUM_WORDS;

    logic              clk = 1'b0;
    logic              rst;
    logic              bla_done;
    logic [BW-1:0]     line_buffer;
    logic [ADDR_W-1:0] fb_base;
    logic              fb_ack;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [WORD_W-1:0] fb_wdata;
    logic              flush_busy;
    logic              flush_done;
    logic [7:0]        words_written;

    line_buffer_flush #(
        .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .SKIP_ZERO(1)
    ) dut (
        .clk(clk), .rst(rst), .bla_done(bla_done), .line_buffer(line_buffer),
        .fb_base(fb_base), .fb_wr_en(fb_wr_en), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .fb_ack(fb_ack), .flush_busy(flush_busy), .flush_done(flush_done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ack_mode;   // 0: ack tied high, 1: random, 2: hold low 5 write cycles, 3: never

    // Reference model state: pending writes of the current flush and next event time.
    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [WORD_W-1:0] d;
    } obs_t;

    wr_t   m_q[$];
    obs_t  wlog[$];
    bit    m_busy = 1'b0;
    bit    m_wr   = 1'b0;
    int    m_pos;
    int    m_deadline;
    logic              exp_wr;
    logic              exp_busy;
    logic              exp_done;
    logic [7:0]        exp_cnt;
    logic [ADDR_W-1:0] exp_addr;
    logic [WORD_W-1:0] exp_data;

    // Edge of the next event: every word from the current position costs one edge,
    // the next non-empty word raises a request, otherwise the done pulse follows the last word.
    function automatic int next_deadline();
        if (m_q.size() > 0) return cyc + (m_q[0].idx - m_pos);
        return cyc + (NUM_WORDS - m_pos);
    endfunction

    // Reference model and accepted-write log, advanced on each rising edge.
    always @(posedge clk) begin
        logic [WORD_W-1:0] w;
        cyc = cyc + 1;
        if (!rst && fb_wr_en && fb_ack) wlog.push_back({fb_addr, fb_wdata});
        exp_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_wr = 1'b0; m_q.delete();
            exp_wr = 1'b0; exp_busy = 1'b0; exp_cnt = 8'd0;
        end else if (!m_busy) begin
            if (bla_done) begin
                m_q.delete();
                for (int k = 0; k < NUM_WORDS; k++) begin
                    w = line_buffer[k*WORD_W +: WORD_W];
                    if (w != 0) m_q.push_back('{k, ADDR_W'(fb_base + k), w});
                end
                m_busy = 1'b1; m_pos = -1; exp_busy = 1'b1; exp_cnt = 8'd0;
                m_deadline = next_deadline();
            end
        end else if (m_wr) begin
            if (fb_ack) begin
                m_wr = 1'b0; exp_wr = 1'b0;
                if (exp_cnt != 8'(NUM_WORDS)) exp_cnt = exp_cnt + 8'd1;
                m_pos = m_q[0].idx;
                void'(m_q.pop_front());
                m_deadline = next_deadline();
            end
        end else if (cyc == m_deadline) begin
            if (m_q.size() > 0) begin
                m_wr = 1'b1; exp_wr = 1'b1;
                exp_addr = m_q[0].addr; exp_data = m_q[0].data;
            end else begin
                m_busy = 1'b0; exp_busy = 1'b0; exp_done = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic pulse(input logic [BW-1:0] b, input logic [ADDR_W-1:0] base);
        @(negedge clk);
        line_buffer = b; fb_base = base; bla_done = 1'b1;
        @(negedge clk);
        bla_done = 1'b0;
    endtask

    // Wait for flush_done, counting busy and write-request cycles on the way.
    task automatic wait_done(input int budget, output int busy_n, output int wr_n);
        bit seen = 1'b0;
        busy_n = 0; wr_n = 0;
        for (int i = 0; i < budget; i++) begin
            if (flush_done) begin seen = 1'b1; break; end
            busy_n += int'(flush_busy);
            wr_n   += int'(fb_wr_en);
            @(negedge clk);
        end
        chk("flush_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_wr(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fb_wr_en) begin seen = 1'b1; break; end
        end
        chk("wr_en_seen", 64'(seen), 64'd1);
    endtask

    function automatic logic [BW-1:0] rand_buf(input int dens);
        logic [BW-1:0]     b;
        logic [WORD_W-1:0] w;
        b = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if ($urandom_range(0, 15) < dens) begin
                w = $urandom;
                if (w == 0) w = 32'd1;
                b[k*WORD_W +: WORD_W] = w;
            end
        end
        return b;
    endfunction

    initial begin
        logic [BW-1:0] b;
        int            busy_n;
        int            wr_n;
        int            off;
        int            dset[4];
        bit            got_done;

        rst = 1'b1; bla_done = 1'b1; fb_ack = 1'b1; ack_mode = 0;
        line_buffer = rand_buf(16); fb_base = 16'h1234;

        // Per-cycle comparison of every output against the reference model.
        fork
            forever begin
                @(negedge clk);
                chk("fb_wr_en", 64'(fb_wr_en), 64'(exp_wr));
                chk("flush_busy", 64'(flush_busy), 64'(exp_busy));
                chk("flush_done", 64'(flush_done), 64'(exp_done));
                chk("words_written", 64'(words_written), 64'(exp_cnt));
                if (exp_wr) begin
                    chk("fb_addr", 64'(fb_addr), 64'(exp_addr));
                    chk("fb_wdata", 64'(fb_wdata), 64'(exp_data));
                end
            end
            begin : ack_drv
                int hold_cnt = 0;
                forever begin
                    @(negedge clk);
                    if (ack_mode != 2) hold_cnt = 0;
                    case (ack_mode)
                        0: fb_ack = 1'b1;
                        1: fb_ack = ($urandom_range(0, 3) == 0);
                        2: begin
                            if (fb_wr_en && hold_cnt < 5) begin
                                fb_ack = 1'b0; hold_cnt++;
                            end else begin
                                fb_ack = fb_wr_en;
                            end
                        end
                        default: fb_ack = 1'b0;
                    endcase
                end
            end
        join_none

        // Reset held two edges with bla_done and ack high: nothing captured.
        repeat (2) @(negedge clk);
        rst = 1'b0; bla_done = 1'b0;
        chk("rst_busy", 64'(flush_busy), 64'd0);
        chk("rst_wr_en", 64'(fb_wr_en), 64'd0);
        chk("rst_addr", 64'(fb_addr), 64'd0);
        chk("rst_wdata", 64'(fb_wdata), 64'd0);
        chk("rst_count", 64'(words_written), 64'd0);
        repeat (3) @(negedge clk);
        chk("rst_no_capture", 64'(flush_busy), 64'd0);

        // All-zero tile: 129 busy cycles, no writes.
        pulse('0, 16'h0000);
        wait_done(400, busy_n, wr_n);
        chk("zero_busy_cycles", 64'(busy_n), 64'd129);
        chk("zero_wr_cycles", 64'(wr_n), 64'd0);
        chk("zero_count", 64'(words_written), 64'd0);

        // First and last bits set, ack tied high.
        b = '0; b[0] = 1'b1; b[BW-1] = 1'b1;
        off = wlog.size();
        pulse(b, 16'h0100);
        wait_done(400, busy_n, wr_n);
        chk("ends_nwrites", 64'(wlog.size() - off), 64'd2);
        if (wlog.size() >= off + 2) begin
            chk("ends_w0", 64'(wlog[off]),     {16'h0, 16'h0100, 32'h0000_0001});
            chk("ends_w1", 64'(wlog[off + 1]), {16'h0, 16'h017F, 32'h8000_0000});
        end
        chk("ends_count", 64'(words_written), 64'd2);

        // Ack withheld for five write cycles: one request held six cycles, one write.
        ack_mode = 2;
        b = '0; b[3*WORD_W +: WORD_W] = 32'hDEAD_BEEF;
        off = wlog.size();
        pulse(b, 16'h0200);
        wait_done(400, busy_n, wr_n);
        chk("hold_wr_cycles", 64'(wr_n), 64'd6);
        chk("hold_nwrites", 64'(wlog.size() - off), 64'd1);
        if (wlog.size() >= off + 1) chk("hold_w0", 64'(wlog[off]), {16'h0, 16'h0203, 32'hDEAD_BEEF});
        ack_mode = 0;

        // Address wraps past the top of the frame buffer.
        b = '0; b[20*WORD_W +: WORD_W] = 32'h1234_5678;
        off = wlog.size();
        pulse(b, 16'hFFF0);
        wait_done(400, busy_n, wr_n);
        chk("wrap_nwrites", 64'(wlog.size() - off), 64'd1);
        if (wlog.size() >= off + 1) chk("wrap_w0", 64'(wlog[off]), {16'h0, 16'h0004, 32'h1234_5678});

        // New tile offered during a write is ignored.
        ack_mode = 3;
        b = '0; b[5*WORD_W +: WORD_W] = 32'hA5A5_A5A5;
        off = wlog.size();
        pulse(b, 16'h0300);
        wait_wr(200);
        pulse('1, 16'h0800);
        repeat (2) @(negedge clk);
        ack_mode = 0;
        wait_done(400, busy_n, wr_n);
        chk("busy_nwrites", 64'(wlog.size() - off), 64'd1);
        if (wlog.size() >= off + 1) chk("busy_w0", 64'(wlog[off]), {16'h0, 16'h0305, 32'hA5A5_A5A5});
        chk("busy_count", 64'(words_written), 64'd1);

        // Reset during a write drops it with no done pulse; a fresh flush then works.
        ack_mode = 3;
        b = '0; b[10*WORD_W +: WORD_W] = 32'h0BAD_F00D;
        pulse(b, 16'h0400);
        wait_wr(200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_wr_en", 64'(fb_wr_en), 64'd0);
        chk("mrst_busy", 64'(flush_busy), 64'd0);
        got_done = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (flush_done) got_done = 1'b1;
        end
        chk("mrst_no_done", 64'(got_done), 64'd0);
        ack_mode = 1;
        b = '0; b[0 +: WORD_W] = 32'h1111_1111; b[127*WORD_W +: WORD_W] = 32'h2222_2222;
        off = wlog.size();
        pulse(b, 16'h0040);
        wait_done(2000, busy_n, wr_n);
        chk("mrst_nwrites", 64'(wlog.size() - off), 64'd2);
        if (wlog.size() >= off + 2) begin
            chk("mrst_w0", 64'(wlog[off]),     {16'h0, 16'h0040, 32'h1111_1111});
            chk("mrst_w1", 64'(wlog[off + 1]), {16'h0, 16'h00BF, 32'h2222_2222});
        end
        chk("mrst_count", 64'(words_written), 64'd2);

        // Random tiles, bases, ack timing, overlapping bla_done and rare resets.
        dset = '{0, 1, 8, 16};
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 799) == 0);
            bla_done = ($urandom_range(0, 9) == 0);
            if (bla_done) begin
                line_buffer = rand_buf(dset[$urandom_range(0, 3)]);
                fb_base     = 16'($urandom);
            end
        end
        rst = 1'b0; bla_done = 1'b0; ack_mode = 0;
        repeat (300) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
